// File: rtl/divisor_flotante_secuencial.sv
// Sequential GP02 mini-float divider: exponent subtract/re-bias plus a restoring
// significand divider producing one quotient bit per clock.
module divisor_flotante_secuencial #(
  parameter int unsigned NB_EXP  = 4,
  parameter int unsigned NB_MANT = 3,
  parameter int unsigned BIAS    = 7
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [NB_EXP+NB_MANT:0]   i_dividendo,
  input  logic [NB_EXP+NB_MANT:0]   i_divisor,
  output logic                      o_busy,
  output logic                      o_valid,
  output logic [NB_EXP+NB_MANT:0]   o_cociente,
  output logic                      o_div_zero,
  output logic                      o_overflow,
  output logic                      o_underflow
);

  localparam int unsigned NbWord = NB_EXP + NB_MANT + 1;
  localparam int unsigned NbQ    = NB_MANT + 2;
  localparam int unsigned NbCnt  = $clog2(NbQ + 1);
  localparam int unsigned NbE    = NB_EXP + 2;

  localparam logic [NbCnt-1:0]      LastIter = NbCnt'(NbQ - 1);
  localparam logic signed [NbE-1:0] BiasS    = NbE'(BIAS);

  typedef enum logic [1:0] {StIdle, StCalc, StNorm} state_e;

  state_e                state_q;
  logic                  sign_q;
  logic [NB_EXP-1:0]     ea_q;
  logic [NB_EXP-1:0]     eb_q;
  logic [NB_MANT:0]      mb_q;
  logic [NbQ-1:0]        rem_q;
  logic [NbQ-1:0]        q_q;
  logic [NbCnt-1:0]      cnt_q;
  logic                  busy_q;
  logic                  valid_q;
  logic [NbWord-1:0]     cociente_q;
  logic                  div_zero_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic                  rem_ge;
  logic [NbQ-1:0]        rem_sub;
  logic [NbQ-1:0]        rem_d;
  logic [NbQ-1:0]        q_d;
  logic                  adj;
  logic [NB_MANT-1:0]    mant_n;
  logic signed [NbE-1:0] e_calc;
  logic [NbWord-1:0]     result_d;
  logic                  div_zero_d;
  logic                  overflow_d;
  logic                  underflow_d;

  // One restoring step; rem_sub < MB < 2^(NB_MANT+1), so the shift never loses a set bit.
  always_comb begin
    rem_ge  = rem_q >= {1'b0, mb_q};
    rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_d   = {rem_sub[NbQ-2:0], 1'b0};
    q_d     = {q_q[NbQ-2:0], rem_ge};
  end

  always_comb begin
    adj    = ~q_q[NbQ-1];
    mant_n = q_q[NbQ-1] ? q_q[NB_MANT:1] : q_q[NB_MANT-1:0];
    e_calc = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + BiasS
             - $signed({{(NbE-1){1'b0}}, adj});

    result_d    = {sign_q, {NB_EXP{1'b0}}, {NB_MANT{1'b0}}};
    div_zero_d  = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (eb_q == '0) begin
      div_zero_d = 1'b1;
      result_d   = {sign_q, {NB_EXP{1'b1}}, {NB_MANT{1'b1}}};
    end else if (ea_q == '0) begin
      result_d = {sign_q, {NB_EXP{1'b0}}, {NB_MANT{1'b0}}};
    end else if (!e_calc[NbE-1] && e_calc[NB_EXP]) begin
      // Positive and at least 2^NB_EXP: beyond the largest exponent code.
      overflow_d = 1'b1;
      result_d   = {sign_q, {NB_EXP{1'b1}}, {NB_MANT{1'b1}}};
    end else if (e_calc[NbE-1] || (e_calc == '0)) begin
      underflow_d = 1'b1;
      result_d    = {sign_q, {NB_EXP{1'b0}}, {NB_MANT{1'b0}}};
    end else begin
      result_d = {sign_q, e_calc[NB_EXP-1:0], mant_n};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      sign_q      <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      mb_q        <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      cociente_q  <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            sign_q      <= i_dividendo[NbWord-1] ^ i_divisor[NbWord-1];
            ea_q        <= i_dividendo[NbWord-2:NB_MANT];
            eb_q        <= i_divisor[NbWord-2:NB_MANT];
            mb_q        <= {1'b1, i_divisor[NB_MANT-1:0]};
            rem_q       <= {2'b01, i_dividendo[NB_MANT-1:0]};
            q_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            state_q     <= StCalc;
          end
        end
        StCalc: begin
          rem_q <= rem_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIter) begin
            state_q <= StNorm;
          end
        end
        StNorm: begin
          cociente_q  <= result_d;
          div_zero_q  <= div_zero_d;
          overflow_q  <= overflow_d;
          underflow_q <= underflow_d;
          valid_q     <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_valid     = valid_q;
  assign o_cociente  = cociente_q;
  assign o_div_zero  = div_zero_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

endmodule
